// File: rtl/prediction_pkg.sv
// Shared constants and entry layout for the fetch-stage branch target buffer.
package prediction_pkg;

  // Index width of the default configuration (16 entries).
  localparam int BTB_INDEX_WIDTH_DEFAULT = 4;

  // Targets are word aligned, so only bits [31:2] are stored.
  localparam int BTB_TARGET_WIDTH = 30;

  // Tag is everything above the index and the two byte-offset bits.
  localparam int BTB_TAG_WIDTH = 32 - BTB_INDEX_WIDTH_DEFAULT - 2;

  // Sequential fetch increment.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Field order of one entry: {valid, tag, target[31:2]}.
  typedef struct packed {
    logic                        valid;
    logic [BTB_TAG_WIDTH-1:0]    tag;
    logic [BTB_TARGET_WIDTH-1:0] target;
  } btb_entry_t;

  // Tag width for an arbitrary index width.
  function automatic int btb_tag_width(input int index_width);
    return 32 - index_width - 2;
  endfunction

endpackage

// File: rtl/btb_entry_array.sv
// Entry storage for the branch target buffer: one combinational read port,
// one write port. Only the valid bits are reset; tag/target contents are
// meaningless until the valid bit is set by a write.
module btb_entry_array
  import prediction_pkg::*;
#(
  parameter int INDEX_WIDTH = BTB_INDEX_WIDTH_DEFAULT,
  parameter int TAG_WIDTH   = btb_tag_width(INDEX_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [INDEX_WIDTH-1:0]      read_index,
  output logic                        read_valid,
  output logic [TAG_WIDTH-1:0]        read_tag,
  output logic [BTB_TARGET_WIDTH-1:0] read_target,
  input  logic                        write_en,
  input  logic                        write_invalidate,
  input  logic [INDEX_WIDTH-1:0]      write_index,
  input  logic [TAG_WIDTH-1:0]        write_tag,
  input  logic [BTB_TARGET_WIDTH-1:0] write_target
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  // Flattened views of the per-entry registers for the read mux.
  logic [DEPTH-1:0]            valid_bits;
  logic [TAG_WIDTH-1:0]        tag_bits    [DEPTH];
  logic [BTB_TARGET_WIDTH-1:0] target_bits [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [INDEX_WIDTH-1:0] ENTRY_INDEX = INDEX_WIDTH'(gi);

      logic                        valid_reg;
      logic [TAG_WIDTH-1:0]        tag_reg;
      logic [BTB_TARGET_WIDTH-1:0] target_reg;
      logic                        selected;

      assign selected = write_en && (write_index == ENTRY_INDEX);

      // Valid bit: cleared by reset (reset beats a concurrent write), set by a
      // write, cleared by an invalidating write.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
        end else if (selected) begin
          valid_reg <= !write_invalidate;
        end
      end

      // Payload: only a real (non-invalidating) write outside reset touches it.
      always_ff @(posedge clk) begin
        if (rst_n && selected && !write_invalidate) begin
          tag_reg    <= write_tag;
          target_reg <= write_target;
        end
      end

      assign valid_bits[gi]  = valid_reg;
      assign tag_bits[gi]    = tag_reg;
      assign target_bits[gi] = target_reg;
    end
  endgenerate

  // Zero-latency read of the pre-write contents.
  assign read_valid  = valid_bits[read_index];
  assign read_tag    = tag_bits[read_index];
  assign read_target = target_bits[read_index];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer on the fetch next-PC path.
// Looks up the fetch PC combinationally, combines the hit with the direction
// counter MSB to select next_pc, and carries hit/target through ID and EX.
// Optional macro BTB_PERF_CNT_EN adds lookup/hit performance counters.
module branch_target_buffer
  import prediction_pkg::*;
#(
  parameter int BTB_INDEX_WIDTH           = BTB_INDEX_WIDTH_DEFAULT,
  parameter int JUMP_STATUS_COUNTER_WIDTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall,
  input  logic                                 flush_id,
  input  logic                                 flush_ex,
  input  logic [31:0]                          pc,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] HP_count,
  input  logic                                 update_en,
  input  logic [31:0]                          update_pc,
  input  logic [31:0]                          update_target,
  input  logic                                 update_invalidate,
  output logic                                 btb_hit,
  output logic                                 predict_taken,
  output logic [31:0]                          next_pc,
  output logic                                 btb_hit_id,
  output logic                                 btb_hit_ex,
  output logic [31:0]                          pred_target_id,
  output logic [31:0]                          pred_target_ex
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_lookups,
  output logic [31:0]                          perf_hits
`endif
);

  localparam int TAG_WIDTH = btb_tag_width(BTB_INDEX_WIDTH);

  logic [BTB_INDEX_WIDTH-1:0]  fetch_index;
  logic [TAG_WIDTH-1:0]        fetch_tag;
  logic                        entry_valid;
  logic [TAG_WIDTH-1:0]        entry_tag;
  logic [BTB_TARGET_WIDTH-1:0] entry_target;
  logic [31:0]                 fetch_target;

  assign fetch_index = pc[BTB_INDEX_WIDTH+1:2];
  assign fetch_tag   = pc[31:BTB_INDEX_WIDTH+2];

  btb_entry_array #(
    .INDEX_WIDTH (BTB_INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_entries (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_index       (fetch_index),
    .read_valid       (entry_valid),
    .read_tag         (entry_tag),
    .read_target      (entry_target),
    .write_en         (update_en),
    .write_invalidate (update_invalidate),
    .write_index      (update_pc[BTB_INDEX_WIDTH+1:2]),
    .write_tag        (update_pc[31:BTB_INDEX_WIDTH+2]),
    .write_target     (update_target[31:2])
  );

  // Byte-offset bits and lower counter bits play no part in the lookup.
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], update_pc[1:0], update_target[1:0], HP_count};

  // Tag compare and next-PC selection; pc + 4 wraps naturally at 32 bits.
  always_comb begin
    btb_hit       = entry_valid && (entry_tag == fetch_tag);
    predict_taken = btb_hit && HP_count[JUMP_STATUS_COUNTER_WIDTH-1];
    fetch_target  = btb_hit ? {entry_target, 2'b00} : 32'd0;
    next_pc       = predict_taken ? {entry_target, 2'b00} : (pc + PC_STEP);
  end

  // ID/EX copies: flush_ex kills both even under stall; flush_id kills ID only
  // while EX still takes the previous ID contents.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_ex) begin
      btb_hit_id     <= 1'b0;
      btb_hit_ex     <= 1'b0;
      pred_target_id <= 32'd0;
      pred_target_ex <= 32'd0;
    end else if (!PL_stall) begin
      btb_hit_ex     <= btb_hit_id;
      pred_target_ex <= pred_target_id;
      btb_hit_id     <= flush_id ? 1'b0 : btb_hit;
      pred_target_id <= flush_id ? 32'd0 : fetch_target;
    end else if (flush_id) begin
      btb_hit_id     <= 1'b0;
      pred_target_id <= 32'd0;
    end
  end

`ifdef BTB_PERF_CNT_EN
  // Count unstalled lookups and the hits among them; free-running wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lookups <= 32'd0;
      perf_hits    <= 32'd0;
    end else if (!PL_stall) begin
      perf_lookups <= perf_lookups + 32'd1;
      if (btb_hit) begin
        perf_hits <= perf_hits + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios followed by
// randomized traffic, all checked against an entry/pipeline reference model.
module tb_branch_target_buffer;

  localparam int IW    = 4;
  localparam int JSCW  = 2;
  localparam int DEPTH = 2 ** IW;

  logic        clk;
  logic        rst_n;
  logic        PL_stall;
  logic        flush_id;
  logic        flush_ex;
  logic [31:0] pc;
  logic [1:0]  HP_count;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_invalidate;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] next_pc;
  logic        btb_hit_id;
  logic        btb_hit_ex;
  logic [31:0] pred_target_id;
  logic [31:0] pred_target_ex;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
`endif

  branch_target_buffer #(
    .BTB_INDEX_WIDTH           (IW),
    .JUMP_STATUS_COUNTER_WIDTH (JSCW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PL_stall          (PL_stall),
    .flush_id          (flush_id),
    .flush_ex          (flush_ex),
    .pc                (pc),
    .HP_count          (HP_count),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_target     (update_target),
    .update_invalidate (update_invalidate),
    .btb_hit           (btb_hit),
    .predict_taken     (predict_taken),
    .next_pc           (next_pc),
    .btb_hit_id        (btb_hit_id),
    .btb_hit_ex        (btb_hit_ex),
    .pred_target_id    (pred_target_id),
    .pred_target_ex    (pred_target_ex)
`ifdef BTB_PERF_CNT_EN
    ,
    .perf_lookups      (perf_lookups),
    .perf_hits         (perf_hits)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model: per slot, remember the full PC and target last written.
  bit          m_valid [DEPTH];
  logic [31:0] m_pc    [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  logic        m_id_hit, m_ex_hit;
  logic [31:0] m_id_tgt, m_ex_tgt;
  logic [31:0] m_lookups, m_hits;

  function automatic int slot_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = slot_of(a);
    return m_valid[s] && ((m_pc[s] >> (IW + 2)) == (a >> (IW + 2)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_id_hit  = 1'b0;
    m_ex_hit  = 1'b0;
    m_id_tgt  = 32'd0;
    m_ex_tgt  = 32'd0;
    m_lookups = 32'd0;
    m_hits    = 32'd0;
  endtask

  task automatic idle();
    PL_stall          = 1'b0;
    flush_id          = 1'b0;
    flush_ex          = 1'b0;
    update_en         = 1'b0;
    update_invalidate = 1'b0;
    update_pc         = 32'd0;
    update_target     = 32'd0;
  endtask

  // One clock: check the lookup before the edge, advance the model at the
  // edge, then check the pipelined copies just after it.
  task automatic cycle();
    logic        e_hit, e_taken;
    logic [31:0] e_tgt, e_next;
    int          s;
    #1;
    e_hit   = model_hit(pc);
    e_tgt   = e_hit ? (m_tgt[slot_of(pc)] & 32'hFFFF_FFFC) : 32'd0;
    e_taken = e_hit && HP_count[1];
    e_next  = e_taken ? e_tgt : pc + 32'd4;
    chk("btb_hit", {31'd0, btb_hit}, {31'd0, e_hit});
    chk("predict_taken", {31'd0, predict_taken}, {31'd0, e_taken});
    chk("next_pc", next_pc, e_next);
    $display("[%0t] %s pc=%h hp=%0d upd=%0d/%h->%h inv=%0d stall=%0d fid=%0d fex=%0d rst_n=%0d next_pc=%h",
             $time, phase, pc, HP_count, update_en, update_pc, update_target,
             update_invalidate, PL_stall, flush_id, flush_ex, rst_n, next_pc);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (flush_ex) begin
        m_id_hit = 1'b0; m_id_tgt = 32'd0;
        m_ex_hit = 1'b0; m_ex_tgt = 32'd0;
      end else if (!PL_stall) begin
        m_ex_hit = m_id_hit;
        m_ex_tgt = m_id_tgt;
        m_id_hit = flush_id ? 1'b0 : e_hit;
        m_id_tgt = flush_id ? 32'd0 : e_tgt;
      end else if (flush_id) begin
        m_id_hit = 1'b0;
        m_id_tgt = 32'd0;
      end
      if (!PL_stall) begin
        m_lookups = m_lookups + 32'd1;
        if (e_hit) m_hits = m_hits + 32'd1;
      end
      if (update_en) begin
        s = slot_of(update_pc);
        if (update_invalidate) begin
          m_valid[s] = 1'b0;
        end else begin
          m_valid[s] = 1'b1;
          m_pc[s]    = update_pc;
          m_tgt[s]   = update_target;
        end
      end
    end
    #1;
    chk("btb_hit_id", {31'd0, btb_hit_id}, {31'd0, m_id_hit});
    chk("btb_hit_ex", {31'd0, btb_hit_ex}, {31'd0, m_ex_hit});
    chk("pred_target_id", pred_target_id, m_id_tgt);
    chk("pred_target_ex", pred_target_ex, m_ex_tgt);
`ifdef BTB_PERF_CNT_EN
    chk("perf_lookups", perf_lookups, m_lookups);
    chk("perf_hits", perf_hits, m_hits);
`endif
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] upper;
    case ($urandom_range(0, 2))
      0:       upper = 32'h0;
      1:       upper = 32'h1;
      default: upper = 32'h03FF_FFFF;
    endcase
    return (upper << (IW + 2)) | (32'($urandom_range(0, DEPTH - 1)) << 2);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n    = 1'b0;
    pc       = 32'h100;
    HP_count = 2'b00;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;

    // 1. Post-reset lookup misses.
    phase = "reset";
    pc = 32'h100; HP_count = 2'b00;
    cycle();

    // 2. Install 0x100 -> 0x200, then look it up taken and not taken.
    phase = "taken";
    update_en = 1'b1; update_pc = 32'h100; update_target = 32'h200; pc = 32'h0;
    cycle();
    idle();
    pc = 32'h100; HP_count = 2'b11;
    cycle();
    chk("t2_next_taken", next_pc, 32'h200);
    HP_count = 2'b01;
    cycle();

    // 3. Same index, different tag.
    phase = "alias";
    pc = 32'h140; HP_count = 2'b11;
    cycle();

    // 4. Same-cycle read/write returns old contents.
    phase = "collide";
    update_en = 1'b1; update_pc = 32'h100; update_target = 32'h300;
    pc = 32'h100; HP_count = 2'b11;
    cycle();
    idle();
    cycle();

    // 5. Stall holds the ID copy; flush_ex clears both copies.
    phase = "stall";
    cycle();
    PL_stall = 1'b1; pc = 32'h0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_hold_target", pred_target_id, 32'h300);
    phase = "flush_ex";
    flush_ex = 1'b1;
    cycle();
    idle();
    phase = "flush_id";
    pc = 32'h100; cycle();
    flush_id = 1'b1; cycle();
    idle(); cycle();

    // 6. Invalidate and pc+4 wrap.
    phase = "invalidate";
    update_en = 1'b1; update_invalidate = 1'b1; update_pc = 32'h100;
    cycle();
    idle();
    cycle();
    phase = "wrap";
    pc = 32'hFFFF_FFFC; HP_count = 2'b11;
    cycle();
    chk("t6_wrap", next_pc, 32'h0000_0000);

    // Reset asserted alongside an update: nothing gets written.
    phase = "reset_update";
    rst_n = 1'b0; update_en = 1'b1; update_pc = 32'h100; update_target = 32'h400;
    cycle();
    rst_n = 1'b1; idle(); pc = 32'h100;
    cycle();

`ifdef BTB_PERF_CNT_EN
    // Ten unstalled lookups with four hits after reset.
    phase = "perf";
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    PL_stall = 1'b1; update_en = 1'b1; update_pc = 32'h100; update_target = 32'h200;
    pc = 32'h500;
    cycle();
    idle();
    for (int i = 0; i < 10; i++) begin
      pc = (i < 4) ? 32'h100 : 32'h104;
      cycle();
    end
    chk("perf_lookups_10", perf_lookups, 32'd10);
    chk("perf_hits_4", perf_hits, 32'd4);
`endif

    // Randomized traffic.
    phase = "random";
    for (int n = 0; n < 600; n++) begin
      rst_n             = ($urandom_range(0, 99) != 0);
      pc                = rand_pc();
      HP_count          = 2'($urandom_range(0, 3));
      PL_stall          = ($urandom_range(0, 3) == 0);
      flush_id          = ($urandom_range(0, 9) == 0);
      flush_ex          = ($urandom_range(0, 19) == 0);
      update_en         = ($urandom_range(0, 2) == 0);
      update_invalidate = ($urandom_range(0, 4) == 0);
      update_pc         = rand_pc();
      update_target     = $urandom();
      cycle();
    end
    rst_n = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
